// File: rtl/sc_speed_scheduler.sv
// sc_speed_scheduler: lane-speed scheduler for the Frogger datapath.
// Emits a one-cycle movement tick per lane, with each lane running at its own
// period. An IDLE/RUN/PAUSE FSM sequences the block, and the lane periods
// shorten as the level rises.
//
// Ports:
//   SC_SPEEDSCHED_CLOCK_50        system clock
//   SC_SPEEDSCHED_RESET_InLow     async active-low reset
//   SC_SPEEDSCHED_start_In        pulse: (re)start a run at level 0
//   SC_SPEEDSCHED_stop_In         pulse: stop and return to IDLE
//   SC_SPEEDSCHED_pause_In        level: freeze counters while high
//   SC_SPEEDSCHED_levelup_In      pulse: advance one level (RUN/PAUSE only)
//   SC_SPEEDSCHED_lanemask_InBUS  per-lane enable
//   SC_SPEEDSCHED_tick_OutBUS     per-lane one-cycle tick
//   SC_SPEEDSCHED_level_OutBUS    current level
//   SC_SPEEDSCHED_period_OutBUS   current lane-0 period P
//   SC_SPEEDSCHED_running_Out     high while in RUN
module sc_speed_scheduler #(
    parameter int unsigned          LANES       = 4,
    parameter int unsigned          DATAWIDTH   = 24,
    parameter int unsigned          LEVELWIDTH  = 4,
    parameter logic [DATAWIDTH-1:0] BASE_PERIOD = 24'hFBC520,
    parameter logic [DATAWIDTH-1:0] LEVEL_STEP  = 24'd1000000,
    parameter logic [DATAWIDTH-1:0] MIN_PERIOD  = 24'd2000000,
    parameter logic [DATAWIDTH-1:0] LANE_OFFSET = 24'd250000
) (
    input  logic                  SC_SPEEDSCHED_CLOCK_50,
    input  logic                  SC_SPEEDSCHED_RESET_InLow,
    input  logic                  SC_SPEEDSCHED_start_In,
    input  logic                  SC_SPEEDSCHED_stop_In,
    input  logic                  SC_SPEEDSCHED_pause_In,
    input  logic                  SC_SPEEDSCHED_levelup_In,
    input  logic [LANES-1:0]      SC_SPEEDSCHED_lanemask_InBUS,
    output logic [LANES-1:0]      SC_SPEEDSCHED_tick_OutBUS,
    output logic [LEVELWIDTH-1:0] SC_SPEEDSCHED_level_OutBUS,
    output logic [DATAWIDTH-1:0]  SC_SPEEDSCHED_period_OutBUS,
    output logic                  SC_SPEEDSCHED_running_Out
);

    // Wide enough for level*step + min without overflow.
    localparam int unsigned PW = DATAWIDTH + LEVELWIDTH + 1;
    localparam logic [LEVELWIDTH-1:0] LEVEL_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic clk, rst_n, start, stop, pause, levelup;
    logic [LANES-1:0] mask;

    assign clk     = SC_SPEEDSCHED_CLOCK_50;
    assign rst_n   = SC_SPEEDSCHED_RESET_InLow;
    assign start   = SC_SPEEDSCHED_start_In;
    assign stop    = SC_SPEEDSCHED_stop_In;
    assign pause   = SC_SPEEDSCHED_pause_In;
    assign levelup = SC_SPEEDSCHED_levelup_In;
    assign mask    = SC_SPEEDSCHED_lanemask_InBUS;

    state_t                state_q, state_d;
    logic [DATAWIDTH-1:0]  cnt_q [LANES];
    logic [DATAWIDTH-1:0]  cnt_d [LANES];
    logic [DATAWIDTH-1:0]  lane_limit [LANES];
    logic [LEVELWIDTH-1:0] level_q, level_d;
    logic [DATAWIDTH-1:0]  period_q, period_d;
    logic [LANES-1:0]      tick_q, tick_d;
    logic                  running_q;
    logic                  advance;
    logic                  level_ok;
    logic [PW-1:0]         next_dec;

    // Lane-0 period for a given level: BASE - lvl*STEP, floored at MIN.
    function automatic logic [DATAWIDTH-1:0] period_of(input logic [LEVELWIDTH-1:0] lvl);
        logic [PW-1:0] dec;
        dec = PW'(lvl) * PW'(LEVEL_STEP);
        if (dec + PW'(MIN_PERIOD) > PW'(BASE_PERIOD)) begin
            period_of = MIN_PERIOD;
        end else begin
            period_of = DATAWIDTH'(PW'(BASE_PERIOD) - dec);
        end
    endfunction

    // A level-up is allowed only if the next level still meets the period floor.
    always_comb begin
        next_dec = (PW'(level_q) + PW'(1)) * PW'(LEVEL_STEP);
        level_ok = (next_dec + PW'(MIN_PERIOD) <= PW'(BASE_PERIOD)) && (level_q != LEVEL_MAX);
    end

    // Terminal count per lane: Pi - 1, with Pi = P - i*OFFSET.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_limit[i] = period_q - DATAWIDTH'(i * LANE_OFFSET) - DATAWIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, level and lane counters; stop > start > pause.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tick_d  = '0;
        advance = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (stop) begin
            state_d = IDLE;
            level_d = '0;
            for (int i = 0; i < LANES; i++) cnt_d[i] = '0;
        end else if (start) begin
            state_d = RUN;
            level_d = '0;
            for (int i = 0; i < LANES; i++) cnt_d[i] = '0;
        end else begin
            case (state_q)
                RUN, PAUSE: begin
                    state_d = pause ? PAUSE : RUN;
                    // Count only on cycles that land in RUN, so no tick can appear in PAUSE.
                    advance = !pause;
                    if (levelup && level_ok) begin
                        level_d = level_q + LEVELWIDTH'(1);
                    end
                end
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (advance) begin
            for (int i = 0; i < LANES; i++) begin
                if (!mask[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= lane_limit[i]) begin
                    // >= so a period shortened below the count wraps immediately.
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + DATAWIDTH'(1);
                end
            end
        end

        period_d = period_of(level_d);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
            level_q   <= '0;
            period_q  <= BASE_PERIOD;
            tick_q    <= '0;
            running_q <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) cnt_q[i] <= cnt_d[i];
            level_q   <= level_d;
            period_q  <= period_d;
            tick_q    <= tick_d;
            running_q <= (state_d == RUN);
        end
    end

    assign SC_SPEEDSCHED_tick_OutBUS   = tick_q;
    assign SC_SPEEDSCHED_level_OutBUS  = level_q;
    assign SC_SPEEDSCHED_period_OutBUS = period_q;
    assign SC_SPEEDSCHED_running_Out   = running_q;

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Directed testbench for sc_speed_scheduler using small periods
// (BASE=20, STEP=4, MIN=8, OFFSET=2, 4 lanes).
module tb_sc_speed_scheduler;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 24;
    localparam int unsigned LW    = 4;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             start   = 1'b0;
    logic             stop    = 1'b0;
    logic             pause   = 1'b0;
    logic             levelup = 1'b0;
    logic [LANES-1:0] mask    = '0;
    logic [LANES-1:0] tick;
    logic [LW-1:0]    level;
    logic [DW-1:0]    period;
    logic             running;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int s     = 0;
    int first_t [LANES];
    int last_t  [LANES];
    int n_t     [LANES];

    sc_speed_scheduler #(
        .LANES       (LANES),
        .DATAWIDTH   (DW),
        .LEVELWIDTH  (LW),
        .BASE_PERIOD (24'd20),
        .LEVEL_STEP  (24'd4),
        .MIN_PERIOD  (24'd8),
        .LANE_OFFSET (24'd2)
    ) dut (
        .SC_SPEEDSCHED_CLOCK_50       (clk),
        .SC_SPEEDSCHED_RESET_InLow    (rst_n),
        .SC_SPEEDSCHED_start_In       (start),
        .SC_SPEEDSCHED_stop_In        (stop),
        .SC_SPEEDSCHED_pause_In       (pause),
        .SC_SPEEDSCHED_levelup_In     (levelup),
        .SC_SPEEDSCHED_lanemask_InBUS (mask),
        .SC_SPEEDSCHED_tick_OutBUS    (tick),
        .SC_SPEEDSCHED_level_OutBUS   (level),
        .SC_SPEEDSCHED_period_OutBUS  (period),
        .SC_SPEEDSCHED_running_Out    (running)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the index of the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_log();
        for (int i = 0; i < LANES; i++) begin
            first_t[i] = -1;
            last_t[i]  = -1;
            n_t[i]     = 0;
        end
    endtask

    // Advance n cycles, sampling ticks on each falling edge.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                if (tick[i] === 1'b1) begin
                    if (n_t[i] == 0) first_t[i] = cyc;
                    last_t[i] = cyc;
                    n_t[i]++;
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        run(1);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic pulse_levelup();
        levelup = 1'b1;
        run(1);
        levelup = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run(2);
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL reset_tick: got %0h want 0", tick); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (period !== 24'd20) begin bad++; $display("FAIL reset_period: got %0d want 20", period); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0b want 0", running); end
        rst_n = 1'b1;
        run(1);
    endtask

    task automatic test_run_ticks();
        int exp_p [LANES];
        int exp_n [LANES];
        exp_p = '{20, 18, 16, 14};
        exp_n = '{3, 3, 3, 4};
        mask = 4'hF;
        pulse_start();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL run_running: got %0b want 1", running); end
        clear_log();
        run(60);
        for (int i = 0; i < LANES; i++) begin
            total++;
            if (first_t[i] - s !== exp_p[i]) begin
                bad++; $display("FAIL run_first_lane%0d: got %0d want %0d", i, first_t[i] - s, exp_p[i]);
            end
            total++;
            if (n_t[i] !== exp_n[i]) begin
                bad++; $display("FAIL run_count_lane%0d: got %0d want %0d", i, n_t[i], exp_n[i]);
            end
        end
        total++;
        if (last_t[0] - first_t[0] !== 40) begin
            bad++; $display("FAIL run_repeat_lane0: got %0d want 40", last_t[0] - first_t[0]);
        end
    endtask

    task automatic test_pause();
        mask = 4'hF;
        pulse_start();
        run(10);
        pause = 1'b1;
        clear_log();
        run(7);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got %0b want 0", running); end
        total++;
        if (n_t[0] + n_t[1] + n_t[2] + n_t[3] !== 0) begin
            bad++; $display("FAIL pause_no_ticks: got %0d want 0", n_t[0] + n_t[1] + n_t[2] + n_t[3]);
        end
        pause = 1'b0;
        clear_log();
        run(30);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL pause_resume_running: got %0b want 1", running); end
        total++; if (first_t[0] - s !== 27) begin bad++; $display("FAIL pause_delay_lane0: got %0d want 27", first_t[0] - s); end
        total++; if (first_t[3] - s !== 21) begin bad++; $display("FAIL pause_delay_lane3: got %0d want 21", first_t[3] - s); end
    endtask

    task automatic test_levelup();
        int exp_l [5];
        int exp_p [5];
        exp_l = '{1, 2, 3, 3, 3};
        exp_p = '{16, 12, 8, 8, 8};
        mask = 4'hF;
        pulse_start();
        run(2);
        for (int k = 0; k < 5; k++) begin
            pulse_levelup();
            total++;
            if (level !== LW'(exp_l[k])) begin
                bad++; $display("FAIL levelup%0d_level: got %0d want %0d", k, level, exp_l[k]);
            end
            total++;
            if (period !== DW'(exp_p[k])) begin
                bad++; $display("FAIL levelup%0d_period: got %0d want %0d", k, period, exp_p[k]);
            end
        end
        run(5);
        clear_log();
        run(20);
        total++; if (n_t[3] !== 10) begin bad++; $display("FAIL levelup_lane3_count: got %0d want 10", n_t[3]); end
        total++; if (last_t[3] - first_t[3] !== 18) begin bad++; $display("FAIL levelup_lane3_span: got %0d want 18", last_t[3] - first_t[3]); end
    endtask

    task automatic test_levelup_wrap();
        mask = 4'hF;
        pulse_start();
        run(15);
        clear_log();
        pulse_levelup();
        run(5);
        total++; if (period !== 24'd16) begin bad++; $display("FAIL wrap_period: got %0d want 16", period); end
        total++; if (first_t[0] - s !== 17) begin bad++; $display("FAIL wrap_lane0_tick: got %0d want 17", first_t[0] - s); end
    endtask

    task automatic test_stop_start();
        stop  = 1'b1;
        start = 1'b1;
        run(1);
        stop  = 1'b0;
        start = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL stopstart_running: got %0b want 0", running); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL stopstart_level: got %0d want 0", level); end
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL stopstart_tick: got %0h want 0", tick); end
        clear_log();
        run(30);
        total++;
        if (n_t[0] + n_t[1] + n_t[2] + n_t[3] !== 0) begin
            bad++; $display("FAIL idle_no_ticks: got %0d want 0", n_t[0] + n_t[1] + n_t[2] + n_t[3]);
        end
        pulse_levelup();
        total++; if (level !== 4'd0) begin bad++; $display("FAIL idle_levelup_level: got %0d want 0", level); end
        total++; if (period !== 24'd20) begin bad++; $display("FAIL idle_levelup_period: got %0d want 20", period); end
    endtask

    task automatic test_mask();
        mask = 4'b0101;
        pulse_start();
        clear_log();
        run(40);
        total++; if (n_t[1] !== 0) begin bad++; $display("FAIL mask_lane1: got %0d want 0", n_t[1]); end
        total++; if (n_t[3] !== 0) begin bad++; $display("FAIL mask_lane3: got %0d want 0", n_t[3]); end
        total++; if (n_t[0] !== 2) begin bad++; $display("FAIL mask_lane0_count: got %0d want 2", n_t[0]); end
        total++; if (first_t[2] - s !== 16) begin bad++; $display("FAIL mask_lane2_first: got %0d want 16", first_t[2] - s); end
        stop = 1'b1;
        run(1);
        stop = 1'b0;
    endtask

    task automatic test_reset_midrun();
        mask = 4'hF;
        pulse_start();
        run(10);
        pulse_levelup();
        #2 rst_n = 1'b0;
        #1;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL midreset_running: got %0b want 0", running); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL midreset_level: got %0d want 0", level); end
        total++; if (period !== 24'd20) begin bad++; $display("FAIL midreset_period: got %0d want 20", period); end
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL midreset_tick: got %0h want 0", tick); end
        run(1);
        rst_n = 1'b1;
        clear_log();
        run(30);
        total++;
        if (n_t[0] + n_t[1] + n_t[2] + n_t[3] !== 0) begin
            bad++; $display("FAIL postreset_no_ticks: got %0d want 0", n_t[0] + n_t[1] + n_t[2] + n_t[3]);
        end
        pulse_start();
        clear_log();
        run(25);
        total++; if (first_t[0] - s !== 20) begin bad++; $display("FAIL postreset_first_lane0: got %0d want 20", first_t[0] - s); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_run_ticks();
        test_pause();
        test_levelup();
        test_levelup_wrap();
        test_stop_start();
        test_mask();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
